sd_dat_writer: RTL and testbench
================================

// Module: sd_dat_writer
// PURPOSE
//  4-bit SD-bus data transmitter: sends one 512-byte sector to the card on DAT[3:0] after CMD24 is accepted.
//  Drives the start bit, 1024 data nibbles and per-line CRC16, then the end bit.
//  Then collects the card's CRC-status token and busy phase on DAT0.
//  Sits beside the command controller and shares its sdclk; user data is fetched from a byte RAM by address.
// PARAMETERS
//  RESP_TIMEOUT  64         max sdclk rising edges from end bit to CRC-status start bit
//  BUSY_TIMEOUT  1000000    max sdclk rising edges DAT0 may stay low (card busy) after the token
// PORTS
//  clk        in   1   system clock; all logic on posedge clk
//  rst        in   1   asynchronous reset, active-high
//  sdclk      in   1   SD clock from command controller; edges detected in clk domain (registered copy)
//  sddat_i    in   4   DAT[3:0] input from pad
//  sddat_o    out  4   DAT[3:0] output value
//  sddat_oe   out  1   1: block drives DAT[3:0]; 0: lines released (pull-ups)
//  wstart     in   1   1-clk pulse: begin sector transmit; sampled only when wbusy=0
//  wbusy      out  1   high from accepted wstart until the cycle after wdone
//  wdone      out  1   1-clk pulse: transfer finished, wstatus valid that cycle
//  wstatus    out  2   00 accepted, 01 card CRC error, 10 write error/bad token, 11 timeout
//  inreq      out  1   1-clk pulse: byte fetch request
//  inaddr     out  9   byte address 0..511 for inreq
//  inbyte     in   8   data for inaddr, valid exactly 1 clk after inreq
// BEHAVIOUR
//  Reset values
//  - sddat_o=4'hF, sddat_oe=0, wbusy=0, wdone=0, wstatus=2'b00, inreq=0, inaddr=0.
//  Edge rules
//  - fall = sdclk_q & ~sdclk; rise = ~sdclk_q & sdclk.
//  - Outputs change only on fall; DAT0 is sampled only on rise.
//  - sdclk half-period must be >= 2 clk (clk divider >= 2) so each fetch completes in time.
//  State machine
//  - IDLE:
//    - wstart -> PREFETCH; wbusy=1.
//    - Pulse inreq with inaddr=0; latch inbyte next clk.
//    - Clear the four CRC16 registers to 0; then -> START.
//  - START:
//    - On fall, drive sddat_oe=1, sddat_o=4'h0 (start bit); -> DATA, nibble index n=0.
//  - DATA:
//    - On each fall, drive the high nibble of the held byte when n is even, the low nibble when n is odd.
//    - On an even-n fall, pulse inreq with inaddr=(n/2)+1; latch inbyte before the next even fall.
//    - No request beyond address 511.
//    - CRC: line k bit = nibble bit k; CRC16-CCITT, poly 0x1021, init 0, MSB-first, updated per driven nibble.
//    - After n=1023 is driven -> CRC, j=0.
//  - CRC:
//    - On each fall, line k drives crc_k[15-j]; after j=15 -> END.
//  - END:
//    - On fall, drive 4'hF (end bit) -> RELEASE.
//  - RELEASE:
//    - On the next fall, sddat_oe=0; -> WAITRESP; reset edge counter.
//  - WAITRESP:
//    - On rise: DAT0=0 -> RESP with a 3-bit shift.
//    - Otherwise count; count > RESP_TIMEOUT -> FINISH with status 11.
//  - RESP:
//    - Shift 3 bits on three rises; ignore the 4th (end bit).
//    - Token 010 -> BUSY; 101 -> FINISH with 01; any other -> FINISH with 10.
//  - BUSY:
//    - On rise: DAT0=1 -> FINISH with 00.
//    - Otherwise count; count > BUSY_TIMEOUT -> FINISH with 11.
//  - FINISH:
//    - Pulse wdone 1 clk with wstatus; wbusy drops next clk; -> IDLE.
//    - wstatus holds until the next wstart.
//  Boundary conditions
//  - wstart while wbusy=1: ignored, no effect.
//  - wstart in the same clk as wdone: ignored.
//  - inbyte is sampled only in the clk after inreq; other values are don't-care.
//  - rst mid-transfer: immediately sddat_oe=0, sddat_o=4'hF, state IDLE, no wdone pulse.
//  - sdclk stalled: the block waits indefinitely (no clk-based timeout); timeouts count sdclk edges only.
//  - Counters are sized for BUSY_TIMEOUT and do not wrap before the timeout fires.
// TESTING
//  - All-zero sector, card model returns 010 then 8 busy clocks:
//    - DAT lines show start 0, 1024 nibbles 0, CRC 0x0000 per line, end F.
//    - wdone with wstatus=00.
//  - Sector byte i = i[7:0]: per-line CRC matches a software CRC16-CCITT reference.
//    - inaddr sequence 0..511 with exactly 512 inreq pulses.
//  - Card model returns token 101 -> wstatus=01; token 110 -> wstatus=10; no busy phase is waited on.
//  - No start bit from the card after the end bit -> wdone after RESP_TIMEOUT+1 rises, wstatus=11.
//    - DAT0 held low forever -> wstatus=11 after BUSY_TIMEOUT.
//  - rst asserted at nibble 300:
//    - sddat_oe=0 next clk, wbusy=0, no wdone.
//    - A following wstart completes normally with wstatus=00.
//  - wstart pulsed again during DATA and in the wdone cycle: ignored; a single transfer, single wdone.

Source files
------------

// File: rtl/sd_dat_writer.sv
// SD-bus 4-bit DAT writer: sends one 512-byte sector with per-line CRC16, then
// collects the card's CRC-status token and busy phase on DAT0.
module sd_dat_writer #(
    parameter int RESP_TIMEOUT = 64,
    parameter int BUSY_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdclk,
    input  logic [3:0] sddat_i,
    output logic [3:0] sddat_o,
    output logic       sddat_oe,
    input  logic       wstart,
    output logic       wbusy,
    output logic       wdone,
    output logic [1:0] wstatus,
    output logic       inreq,
    output logic [8:0] inaddr,
    input  logic [7:0] inbyte
);
    localparam int MAX_TO = (BUSY_TIMEOUT > RESP_TIMEOUT) ?
                            ((BUSY_TIMEOUT > 16) ? BUSY_TIMEOUT : 16) :
                            ((RESP_TIMEOUT > 16) ? RESP_TIMEOUT : 16);
    localparam int CW = $clog2(MAX_TO + 2);
    localparam logic [CW-1:0] RESP_LIM = CW'(RESP_TIMEOUT);
    localparam logic [CW-1:0] BUSY_LIM = CW'(BUSY_TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_3    = CW'(3);
    localparam logic [CW-1:0] CNT_15   = CW'(15);

    typedef enum logic [3:0] {
        S_IDLE, S_PREFETCH, S_START, S_DATA, S_CRC, S_END,
        S_RELEASE, S_WAITRESP, S_RESP, S_BUSY, S_FINISH
    } state_t;

    state_t          state, state_next;
    logic            sdclk_q, fall, rise;
    logic            req_q;
    logic [7:0]      byte_q;
    logic [3:0]      lo_q, nib_val;
    logic [9:0]      nib;
    logic [CW-1:0]   cnt;
    logic [2:0]      tok;
    logic [15:0]     crc [4];
    logic [1:0]      fin_status;
    logic            finishing;

    // DAT[3:1] carry nothing back from the card during a write.
    logic unused;
    assign unused = &{1'b0, sddat_i[3:1]};

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    assign fall      = sdclk_q & ~sdclk;
    assign rise      = ~sdclk_q & sdclk;
    assign nib_val   = nib[0] ? lo_q : byte_q[7:4];
    assign wbusy     = (state != S_IDLE);
    assign wdone     = (state == S_FINISH);
    assign finishing = (state_next == S_FINISH) && (state != S_FINISH);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: flops are written with <= so every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first; any path that skips an assignment would infer a latch.
        state_next = state;
        fin_status = 2'b00;
        case (state)
            S_IDLE:     if (wstart) state_next = S_PREFETCH;
            S_PREFETCH: if (req_q) state_next = S_START;
            S_START:    if (fall) state_next = S_DATA;
            S_DATA:     if (fall && nib == 10'd1023) state_next = S_CRC;
            S_CRC:      if (fall && cnt == CNT_15) state_next = S_END;
            S_END:      if (fall) state_next = S_RELEASE;
            S_RELEASE:  if (fall) state_next = S_WAITRESP;
            S_WAITRESP: if (rise) begin
                if (!sddat_i[0]) begin
                    state_next = S_RESP;
                end else if (cnt >= RESP_LIM) begin
                    state_next = S_FINISH;
                    fin_status = 2'b11;
                end
            end
            // Fourth rise is the token end bit; decide only after it.
            S_RESP:     if (rise && cnt == CNT_3) begin
                case (tok)
                    3'b010:  state_next = S_BUSY;
                    3'b101:  begin state_next = S_FINISH; fin_status = 2'b01; end
                    default: begin state_next = S_FINISH; fin_status = 2'b10; end
                endcase
            end
            S_BUSY:     if (rise) begin
                if (sddat_i[0]) begin
                    state_next = S_FINISH;
                    fin_status = 2'b00;
                end else if (cnt >= BUSY_LIM) begin
                    state_next = S_FINISH;
                    fin_status = 2'b11;
                end
            end
            S_FINISH:   state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdclk_q  <= 1'b0;
            sddat_o  <= 4'hF;
            sddat_oe <= 1'b0;
            wstatus  <= 2'b00;
            inreq    <= 1'b0;
            inaddr   <= '0;
            req_q    <= 1'b0;
            byte_q   <= '0;
            lo_q     <= '0;
            nib      <= '0;
            cnt      <= '0;
            tok      <= '0;
            for (int k = 0; k < 4; k++) crc[k] <= '0;
        end else begin
            sdclk_q <= sdclk;
            inreq   <= 1'b0;
            req_q   <= inreq;
            if (req_q) byte_q <= inbyte;
            if (finishing) wstatus <= fin_status;
            case (state)
                S_IDLE: if (wstart) begin
                    inreq   <= 1'b1;
                    inaddr  <= '0;
                    wstatus <= 2'b00;
                    for (int k = 0; k < 4; k++) crc[k] <= '0;
                end
                S_START: if (fall) begin
                    sddat_oe <= 1'b1;
                    sddat_o  <= 4'h0;
                    nib      <= '0;
                end
                S_DATA: if (fall) begin
                    sddat_o <= nib_val;
                    for (int k = 0; k < 4; k++) crc[k] <= crc16_step(crc[k], nib_val[k]);
                    // byte_q is refilled mid-byte, so the low nibble is parked in lo_q.
                    if (!nib[0]) begin
                        lo_q <= byte_q[3:0];
                        if (nib[9:1] != 9'd511) begin
                            inreq  <= 1'b1;
                            inaddr <= nib[9:1] + 9'd1;
                        end
                    end
                    nib <= nib + 10'd1;
                    cnt <= '0;
                end
                S_CRC: if (fall) begin
                    for (int k = 0; k < 4; k++) begin
                        sddat_o[k] <= crc[k][15];
                        crc[k]     <= {crc[k][14:0], 1'b0};
                    end
                    cnt <= cnt + CNT_ONE;
                end
                S_END: if (fall) sddat_o <= 4'hF;
                S_RELEASE: if (fall) begin
                    sddat_oe <= 1'b0;
                    cnt      <= '0;
                end
                S_WAITRESP: if (rise) cnt <= sddat_i[0] ? cnt + CNT_ONE : '0;
                S_RESP: if (rise) begin
                    if (cnt == CNT_3) begin
                        cnt <= '0;
                    end else begin
                        tok <= {tok[1:0], sddat_i[0]};
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_BUSY: if (rise) cnt <= cnt + CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_dat_writer.sv
// Scoreboard bench for sd_dat_writer: random sectors, a byte-RAM model and a
// card model answering the CRC-status/busy phase on DAT0.
module tb_sd_dat_writer;
    localparam int RESP_TIMEOUT = 64;
    localparam int BUSY_TIMEOUT = 100;
    localparam int XFER_LIMIT   = 8000;

    typedef enum int {CARD_NORMAL, CARD_SILENT, CARD_STUCK} card_mode_t;
    typedef struct {
        logic [1:0] status;
        int         rises;
    } done_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sdclk = 1'b0;
    logic [3:0] sddat_i = 4'hF;
    logic [3:0] sddat_o;
    logic       sddat_oe;
    logic       wstart = 1'b0;
    logic       wbusy, wdone;
    logic [1:0] wstatus;
    logic       inreq;
    logic [8:0] inaddr;
    logic [7:0] inbyte = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [512];
    logic [3:0] exp_nib  [$];
    logic [8:0] exp_addr [$];
    done_t      exp_done [$];
    logic       card_q   [$];
    logic       card_idle = 1'b1;
    card_mode_t card_mode = CARD_NORMAL;
    logic [2:0] card_tok  = 3'b010;
    int         card_busy = 0;
    int         hold = 0;
    int         ph = 0;
    logic       end_seen = 1'b0;
    int         rises_after = 0;
    int         nib_seen = 0;

    sd_dat_writer #(.RESP_TIMEOUT(RESP_TIMEOUT), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .sdclk(sdclk), .sddat_i(sddat_i), .sddat_o(sddat_o),
        .sddat_oe(sddat_oe), .wstart(wstart), .wbusy(wbusy), .wdone(wdone),
        .wstatus(wstatus), .inreq(inreq), .inaddr(inaddr), .inbyte(inbyte)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] nibble_at(input int i);
        logic [7:0] b;
        b = mem[i / 2];
        return (i % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    // CRC as the remainder of (line bits * x^16) divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_ref(input int line);
        logic [16:0] rem;
        logic [3:0]  n;
        logic        b;
        rem = '0;
        for (int i = 0; i < 1024 + 16; i++) begin
            b = 1'b0;
            if (i < 1024) begin
                n = nibble_at(i);
                b = n[line];
            end
            rem = {rem[15:0], b};
            if (rem[16]) rem = rem ^ 17'h11021;
        end
        return rem[15:0];
    endfunction

    task automatic build_expected(input card_mode_t mode, input logic [2:0] tok, input int busy_n);
        logic [15:0] c [4];
        logic [3:0]  n;
        done_t       d;
        exp_nib.push_back(4'h0);
        for (int i = 0; i < 1024; i++) exp_nib.push_back(nibble_at(i));
        for (int k = 0; k < 4; k++) c[k] = crc_ref(k);
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 4; k++) n[k] = c[k][15 - j];
            exp_nib.push_back(n);
        end
        exp_nib.push_back(4'hF);
        for (int a = 0; a < 512; a++) exp_addr.push_back(9'(a));
        case (mode)
            CARD_SILENT: begin d.status = 2'b11; d.rises = RESP_TIMEOUT + 1; end
            CARD_STUCK:  begin d.status = 2'b11; d.rises = 8 + BUSY_TIMEOUT; end
            default: begin
                if (tok == 3'b010)      begin d.status = 2'b00; d.rises = 8 + busy_n; end
                else if (tok == 3'b101) begin d.status = 2'b01; d.rises = 7; end
                else                    begin d.status = 2'b10; d.rises = 7; end
            end
        endcase
        exp_done.push_back(d);
    endtask

    // Card reply after the end bit: two idle clocks, start bit, token, end bit, busy.
    task automatic load_card();
        logic [2:0] t;
        card_q.delete();
        card_idle = (card_mode == CARD_STUCK) ? 1'b0 : 1'b1;
        if (card_mode != CARD_SILENT) begin
            t = (card_mode == CARD_STUCK) ? 3'b010 : card_tok;
            card_q.push_back(1'b1);
            card_q.push_back(1'b1);
            card_q.push_back(1'b0);
            card_q.push_back(t[2]);
            card_q.push_back(t[1]);
            card_q.push_back(t[0]);
            card_q.push_back(1'b1);
            if (card_mode == CARD_NORMAL && t == 3'b010)
                for (int i = 0; i < card_busy; i++) card_q.push_back(1'b0);
        end
    endtask

    // Monitor, byte RAM, sdclk generator and card model, all on the falling clk edge.
    always @(negedge clk) begin
        done_t d;
        if (inreq) begin
            check("inreq_expected", 32'(exp_addr.size() != 0), 32'd1);
            if (exp_addr.size() != 0) check("inaddr", 32'(inaddr), 32'(exp_addr.pop_front()));
            inbyte = mem[inaddr];
            hold = 2;
        end else begin
            if (hold > 0) hold--;
            if (hold == 0) inbyte = 8'($urandom);
        end
        if (wdone) begin
            check("wdone_expected", 32'(exp_done.size() != 0), 32'd1);
            if (exp_done.size() != 0) begin
                d = exp_done.pop_front();
                check("wstatus", 32'(wstatus), 32'(d.status));
                check("rises_to_done", 32'(rises_after), 32'(d.rises));
            end
            end_seen  = 1'b0;
            card_idle = 1'b1;
            card_q.delete();
        end
        ph++;
        if (ph == 2) begin
            ph = 0;
            sdclk = ~sdclk;
            if (sdclk) begin
                if (sddat_oe) begin
                    check("dat_drive_expected", 32'(exp_nib.size() != 0), 32'd1);
                    if (exp_nib.size() != 0) begin
                        check("dat_nibble", 32'(sddat_o), 32'(exp_nib.pop_front()));
                        nib_seen++;
                        if (exp_nib.size() == 0) begin
                            end_seen    = 1'b1;
                            rises_after = 0;
                            load_card();
                        end
                    end
                end else if (end_seen) begin
                    rises_after++;
                end
            end else begin
                sddat_i = {3'b111, (card_q.size() != 0) ? card_q.pop_front() : card_idle};
            end
        end
    end

    task automatic wait_nib(input int n);
        for (int c = 0; c < XFER_LIMIT; c++) begin
            if (nib_seen >= n) return;
            @(negedge clk);
        end
        check("nibble_progress", 32'(nib_seen), 32'(n));
    endtask

    task automatic pulse_start();
        wstart = 1'b1;
        @(negedge clk);
        wstart = 1'b0;
        check("wbusy_on_start", 32'(wbusy), 32'd1);
    endtask

    task automatic run_xfer(input card_mode_t mode, input logic [2:0] tok, input int busy_n,
                            input bit poke);
        bit got;
        card_mode = mode;
        card_tok  = tok;
        card_busy = busy_n;
        nib_seen  = 0;
        build_expected(mode, tok, busy_n);
        pulse_start();
        if (poke) begin
            wait_nib(200);
            wstart = 1'b1;
            @(negedge clk);
            wstart = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < XFER_LIMIT; c++) begin
            @(negedge clk);
            if (wdone) begin
                got = 1'b1;
                break;
            end
        end
        check("wdone_seen", 32'(got), 32'd1);
        if (poke) wstart = 1'b1;
        @(negedge clk);
        wstart = 1'b0;
        check("wbusy_after_done", 32'(wbusy), 32'd0);
        repeat (3) @(negedge clk);
        check("wbusy_stays_idle", 32'(wbusy), 32'd0);
        check("nibbles_left", 32'(exp_nib.size()), 32'd0);
        check("addrs_left", 32'(exp_addr.size()), 32'd0);
        exp_nib.delete();
        exp_addr.delete();
        exp_done.delete();
    endtask

    task automatic run_abort();
        card_mode = CARD_NORMAL;
        card_tok  = 3'b010;
        nib_seen  = 0;
        build_expected(CARD_NORMAL, 3'b010, 0);
        pulse_start();
        wait_nib(301);
        #2;
        rst = 1'b1;
        exp_nib.delete();
        exp_addr.delete();
        exp_done.delete();
        @(negedge clk);
        check("abort_oe", 32'(sddat_oe), 32'd0);
        check("abort_dat", 32'(sddat_o), 32'hF);
        check("abort_wbusy", 32'(wbusy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle", 32'(wbusy), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dat", 32'(sddat_o), 32'hF);
        check("rst_oe", 32'(sddat_oe), 32'd0);
        check("rst_wbusy", 32'(wbusy), 32'd0);
        check("rst_wdone", 32'(wdone), 32'd0);
        check("rst_wstatus", 32'(wstatus), 32'd0);
        check("rst_inreq", 32'(inreq), 32'd0);
        check("rst_inaddr", 32'(inaddr), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        run_xfer(CARD_NORMAL, 3'b010, 8, 1'b0);

        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
        run_xfer(CARD_NORMAL, 3'b010, 3, 1'b1);

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        run_xfer(CARD_NORMAL, 3'b101, 0, 1'b0);

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        run_xfer(CARD_NORMAL, 3'b110, 0, 1'b0);

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        run_xfer(CARD_SILENT, 3'b010, 0, 1'b0);

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        run_xfer(CARD_STUCK, 3'b010, 0, 1'b0);

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        run_abort();

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        run_xfer(CARD_NORMAL, 3'b010, int'($urandom_range(0, 5)), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
